memory_arbiter: RTL and testbench

Shares one single-ported memory between the instruction-fetch requester (port 0) and the load/store requester (port 1) of the multicycle core. Each access uses a request/acknowledge handshake. Data accesses have priority, but a streak limit prevents fetch starvation. A timeout converts a hung memory into an error response. The block sits between `programCounter`/`controlUnit` fetch and data paths and a unified memory.

---
 rtl/memory_arbiter_pkg.sv | 23 ++
 rtl/arb_timeout_counter.sv | 41 ++++
 rtl/memory_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int         TCNT_W = 16;

  // Memory sees word addresses only; the low two byte-offset bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Access watchdog: counts cycles spent waiting on memory, flags TIMEOUT-1.
module arb_timeout_counter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [TCNT_W-1:0] load_val,
  input  logic              en,
  output logic              tc
);

  logic [TCNT_W-1:0] count_q, count_d;

  assign tc = (count_q == TCNT_W'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one single-ported memory with
// data priority, a fetch anti-starvation streak limit and an access timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 2);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]         if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;

  logic                cnt_clr, cnt_en, cnt_tc;
  logic                streak_at_max;
  logic [STREAK_W-1:0] streak_inc;

  assign streak_at_max = (streak_q == STREAK_W'(MAX_STREAK));
  assign streak_inc    = streak_at_max ? streak_q : streak_q + 1'b1;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tcnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        cnt_clr = 1'b1;
        // Data wins unless fetch has already waited out MAX_STREAK data grants.
        if (d_req && !(if_req && streak_at_max)) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = word_align(d_addr);
          mem_be_d    = d_be;
          mem_wdata_d = d_wdata;
          streak_d    = if_req ? streak_inc : '0;
          mem_req_d   = 1'b1;
          state_d     = ARB_ACCESS;
        end else if (if_req) begin
          owner_d    = OWN_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = word_align(if_addr);
          mem_be_d   = BE_ALL;
          streak_d   = '0;
          mem_req_d  = 1'b1;
          state_d    = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        cnt_en = 1'b1;
        // A ready arriving on the timeout cycle still counts as a good completion.
        if (mem_ready || cnt_tc) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_err_d   = !mem_ready;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = !mem_ready;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end

      ARB_RESP: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        mem_be_d  = '0;
        state_d   = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for collision,
// starvation and mid-access reset, then randomized traffic against a model.
module tb_memory_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 8;
  localparam int NEVER      = 100;

  logic        clk, rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  memory_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory model: programmable wait states, optional ready noise while idle.
  logic [31:0] mem_arr [256];
  int lat_cfg = 0;
  int lat_cur = 0;
  int wcnt    = 0;
  bit rand_lat = 0;
  bit noise    = 0;

  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt      = 0;
      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end else begin
      if (wcnt == 0) lat_cur = rand_lat ? int'($urandom_range(0, 9)) : lat_cfg;
      if (wcnt == lat_cur) begin
        mem_ready = 1'b1;
        mem_rdata = mem_arr[mem_addr[9:2]];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      wcnt++;
    end
  end

  // Monitor + reference arbitration model.
  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          ack_cyc;
  } txn_t;

  txn_t        txns[$];
  int          cyc = 0;
  int          model_streak = 0;
  int          req_cnt = 0;
  bit          mem_req_prev = 0;
  bit          ack_last = 0;
  bit          hold_if = 0, hold_d = 0;
  logic        exp_port, g_we;
  logic [31:0] exp_snap, g_addr;
  logic [3:0]  g_be;

  task automatic step();
    txn_t t;
    logic exp_err;
    @(posedge clk);
    #1;
    cyc++;
    if (ack_last) begin
      check("ack_one_cycle", 32'({if_ack, d_ack}), 32'h0);
      ack_last = 0;
    end
    if (mem_req && !mem_req_prev) begin
      logic [31:0] ea;
      logic        ew;
      logic [3:0]  eb;
      if (d_req && !(if_req && model_streak == MAX_STREAK)) begin
        exp_port = 1'b1;
        ea = d_addr & 32'hFFFF_FFFC; ew = d_we; eb = d_be;
        model_streak = if_req ? ((model_streak < MAX_STREAK) ? model_streak + 1 : MAX_STREAK) : 0;
        if (d_we) check("grant_wdata", mem_wdata, d_wdata);
      end else begin
        exp_port = 1'b0;
        ea = if_addr & 32'hFFFF_FFFC; ew = 1'b0; eb = 4'hF;
        model_streak = 0;
      end
      check("grant_addr", mem_addr, ea);
      check("grant_we", 32'(mem_we), 32'(ew));
      check("grant_be", 32'(mem_be), 32'(eb));
      exp_snap = mem_arr[ea[9:2]];
      g_addr = mem_addr; g_we = mem_we; g_be = mem_be;
      req_cnt = 0;
    end
    if (mem_req) req_cnt++;
    if (if_ack || d_ack) begin
      exp_err = (lat_cur >= TIMEOUT);
      t.port = d_ack; t.addr = g_addr; t.we = g_we; t.be = g_be;
      t.rdata = d_ack ? d_rdata : if_rdata;
      t.err = d_ack ? d_err : if_err;
      t.ack_cyc = cyc;
      txns.push_back(t);
      check("ack_exclusive", 32'(if_ack & d_ack), 32'h0);
      check("ack_port", 32'(t.port), 32'(exp_port));
      check("ack_err", 32'(t.err), 32'(exp_err));
      check("ack_rdata", t.rdata, exp_err ? 32'h0 : exp_snap);
      check("mem_req_cycles", req_cnt, exp_err ? TIMEOUT : lat_cur + 1);
      ack_last = 1;
      if (if_ack && !hold_if) if_req = 1'b0;
      if (d_ack && !hold_d) d_req = 1'b0;
    end
    mem_req_prev = mem_req;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (txns.size() < n && k < budget) begin
      step();
      k++;
    end
    check("ack_within_budget", 32'(txns.size() >= n), 32'h1);
  endtask

  task automatic check_zero(input string p);
    check({p, "_ctrl"}, 32'({mem_req, mem_we, mem_be, if_ack, if_err, d_ack, d_err}), 32'h0);
    check({p, "_mem_addr"}, mem_addr, 32'h0);
    check({p, "_mem_wdata"}, mem_wdata, 32'h0);
    check({p, "_if_rdata"}, if_rdata, 32'h0);
    check({p, "_d_rdata"}, d_rdata, 32'h0);
    check({p, "_streak"}, 32'(dut.streak_q), 32'h0);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];
  int   t0;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h100, 4'h0, 32'h0,    2,     32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 4};
    vecs[1] = '{1'b0, 1'b0, 32'h103, 4'h0, 32'h0,    0,     32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b1, 32'h204, 4'h3, 32'h1234, 1,     32'h204, 4'h3, 32'hAABBCCDD, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h206, 4'hF, 32'h0,    0,     32'h204, 4'hF, 32'hAABB1234, 1'b0, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h108, 4'h0, 32'h0,    NEVER, 32'h108, 4'hF, 32'h0,        1'b1, 9};
    vecs[5] = '{1'b0, 1'b0, 32'h104, 4'h0, 32'h0,    7,     32'h104, 4'hF, 32'hCAFEF00D, 1'b0, 9};
    vecs[6] = '{1'b1, 1'b0, 32'h300, 4'hF, 32'h0,    NEVER, 32'h300, 4'hF, 32'h0,        1'b1, 9};

    for (int i = 0; i < 256; i++) mem_arr[i] = {8'h5A, 8'(i), 8'(~i), 8'(i * 3)};
    mem_arr[8'h40] = 32'hDEADBEEF;
    mem_arr[8'h41] = 32'hCAFEF00D;
    mem_arr[8'h81] = 32'hAABBCCDD;

    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    step();

    // Directed single transactions.
    for (int i = 0; i < 7; i++) begin
      txns.delete();
      lat_cfg = vecs[i].lat;
      if (vecs[i].port) begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr;
        d_be = vecs[i].be; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      t0 = cyc;
      run_until(1, 40);
      if (txns.size() >= 1) begin
        check($sformatf("v%0d_port", i), 32'(txns[0].port), 32'(vecs[i].port));
        check($sformatf("v%0d_addr", i), txns[0].addr, vecs[i].exp_addr);
        check($sformatf("v%0d_we", i), 32'(txns[0].we), 32'(vecs[i].we));
        check($sformatf("v%0d_be", i), 32'(txns[0].be), 32'(vecs[i].exp_be));
        check($sformatf("v%0d_rdata", i), txns[0].rdata, vecs[i].exp_rdata);
        check($sformatf("v%0d_err", i), 32'(txns[0].err), 32'(vecs[i].exp_err));
        check($sformatf("v%0d_latency", i), txns[0].ack_cyc - t0, vecs[i].exp_lat);
      end
      step();
    end
    check("if_rdata_held", if_rdata, 32'hCAFEF00D);

    // Collision: data first, fetch in the next IDLE.
    txns.delete();
    lat_cfg = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_be = 4'b0011; d_wdata = 32'h1234;
    if_req = 1'b1; if_addr = 32'h100;
    run_until(2, 40);
    if (txns.size() >= 2) begin
      check("coll_first_port", 32'(txns[0].port), 32'h1);
      check("coll_first_we", 32'(txns[0].we), 32'h1);
      check("coll_first_addr", txns[0].addr, 32'h204);
      check("coll_second_port", 32'(txns[1].port), 32'h0);
      check("coll_second_addr", txns[1].addr, 32'h100);
    end
    step();

    // Starvation guard: four data grants, then fetch.
    txns.delete();
    hold_d = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h100;
    run_until(5, 80);
    if (txns.size() >= 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("starve_grant%0d_port", i), 32'(txns[i].port), (i < 4) ? 32'h1 : 32'h0);
    check("starve_streak_cleared", 32'(dut.streak_q), 32'h0);
    hold_d = 0;
    run_until(6, 30);
    step();

    // Reset in the middle of an access.
    txns.delete();
    lat_cfg = NEVER;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    repeat (3) step();
    check("midrst_in_access", 32'(mem_req), 32'h1);
    rst = 1'b0;
    d_req = 1'b0;
    model_streak = 0;
    #1;
    check_zero("midrst");
    step();
    rst = 1'b1;
    repeat (5) step();
    check("midrst_no_ack", 32'(txns.size()), 32'h0);
    check("midrst_idle", 32'(mem_req), 32'h0);
    lat_cfg = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    run_until(1, 20);
    if (txns.size() >= 1) begin
      check("midrst_fresh_rdata", txns[0].rdata, 32'hDEADBEEF);
      check("midrst_fresh_err", 32'(txns[0].err), 32'h0);
    end
    step();

    // Randomized traffic with random wait states and idle ready noise.
    txns.delete();
    rand_lat = 1;
    noise = 1;
    for (int k = 0; k < 20000 && txns.size() < 250; k++) begin
      step();
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
        d_be = 4'($urandom); d_wdata = $urandom;
      end
    end
    check("random_txn_count", 32'(txns.size() >= 250), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
